// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO. Runtime-configurable frame format (5..DATA_W
// data bits, parity mode, 1/2 stop bits), line break generation and back-to-back framing.
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          baud_tick,
  input  logic                          tx_enable,
  input  logic [3:0]                    cfg_data_len,
  input  logic                          cfg_stop2,
  input  logic [2:0]                    cfg_parity,
  input  logic                          cfg_break,
  input  logic                          wr_valid,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_empty,
  output logic                          fifo_full
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BREAK, BREAK_MARK
  } state_t;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              push, pop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign wr_ready   = !fifo_full;
  assign fifo_count = count_q;
  assign push       = wr_valid && !fifo_full && !rst;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Frame format is resolved from the live config only at pop time.
  logic [DATA_W-1:0] head, head_masked;
  logic [3:0]        len_eff;
  logic              par_en, par_val;

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    if (cfg_data_len < 4'd5)                len_eff = 4'd5;
    else if (cfg_data_len > 4'(DATA_W))     len_eff = 4'(DATA_W);
    else                                    len_eff = cfg_data_len;
  end

  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_mask
      assign head_masked[gi] = head[gi] & (4'(gi) < len_eff);
    end
  endgenerate

  always_comb begin
    par_en  = 1'b1;
    par_val = 1'b0;
    case (cfg_parity)
      3'b001:  par_val = ~^head_masked;
      3'b010:  par_val = ^head_masked;
      3'b011:  par_val = 1'b1;
      3'b100:  par_val = 1'b0;
      default: par_en  = 1'b0;
    endcase
  end

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [3:0]        bit_idx_q, bit_idx_d, len_q, len_d;
  logic              stop2_q, stop2_d, par_en_q, par_en_d, par_bit_q, par_bit_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              tx_q, tx_d, busy_q, done_q, done_d;
  logic              start_ok, load;

  assign start_ok = tx_enable && !cfg_break && !fifo_empty;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    bit_idx_d  = bit_idx_q;
    len_d      = len_q;
    stop2_d    = stop2_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    load       = 1'b0;
    pop        = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (cfg_break) begin
          state_d = BREAK;
          tx_d    = 1'b0;
        end else if (start_ok) begin
          load = 1'b1;
        end
      end
      START: begin
        if (baud_tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
          tx_d      = data_q[0];
          data_d    = data_q >> 1;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_idx_q == len_q - 4'd1) begin
            stop_cnt_d = 1'b0;
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            tx_d      = data_q[0];
            data_d    = data_q >> 1;
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            done_d = 1'b1;
            // start_ok excludes cfg_break, so a pending break wins via IDLE.
            if (start_ok) load = 1'b1;
            else          state_d = IDLE;
          end
        end
      end
      BREAK: begin
        tx_d = 1'b0;
        if (!cfg_break) begin
          state_d = BREAK_MARK;
          tx_d    = 1'b1;
        end
      end
      BREAK_MARK: begin
        tx_d = 1'b1;
        if (baud_tick) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (load) begin
      pop        = 1'b1;
      state_d    = START;
      tx_d       = 1'b0;
      data_d     = head;
      len_d      = len_eff;
      stop2_d    = cfg_stop2;
      par_en_d   = par_en;
      par_bit_d  = par_val;
      bit_idx_d  = '0;
      stop_cnt_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      data_q     <= '0;
      bit_idx_q  <= '0;
      len_q      <= 4'd5;
      stop2_q    <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      bit_idx_q  <= bit_idx_d;
      len_q      <= len_d;
      stop2_q    <= stop2_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= (state_d != IDLE);
      done_q     <= done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: serial line is sampled once per bit at the
// baud tick and compared against hand-built frame vectors (bit 0 = start bit).
module tb_uart_tx_fifo;
  localparam int BAUD = 4;
  localparam int LIMIT = 400;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic       tx_enable = 1'b0;
  logic [3:0] cfg_data_len = 4'd8;
  logic       cfg_stop2 = 1'b0;
  logic [2:0] cfg_parity = 3'b000;
  logic       cfg_break = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, tx, tx_busy, tx_done, fifo_empty, fifo_full;
  logic [4:0] fifo_count;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int gap_cnt = 0;
  int bcnt = 0;
  bit watch_gap = 1'b0;

  uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_enable(tx_enable),
    .cfg_data_len(cfg_data_len), .cfg_stop2(cfg_stop2), .cfg_parity(cfg_parity),
    .cfg_break(cfg_break), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done),
    .fifo_count(fifo_count), .fifo_empty(fifo_empty), .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (bcnt == BAUD - 1) begin
      bcnt = 0;
      baud_tick = 1'b1;
    end else begin
      bcnt = bcnt + 1;
      baud_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt = done_cnt + 1;
    if (watch_gap && tx_busy !== 1'b1) gap_cnt = gap_cnt + 1;
  end

  task automatic push(input logic [7:0] d);
    wr_data  = d;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic record(input int nbits, output logic [15:0] v, output bit tmo);
    int n;
    v = '0;
    tmo = 1'b0;
    n = 0;
    while (tx !== 1'b0 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) tmo = 1'b1;
    for (int k = 0; k < nbits && !tmo; k++) begin
      n = 0;
      while (baud_tick !== 1'b1 && n < LIMIT) begin
        @(negedge clk);
        n++;
      end
      if (baud_tick !== 1'b1) tmo = 1'b1;
      v[k] = tx;
      if (k < nbits - 1) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, output logic [15:0] v,
                            output bit tmo, output logic done_seen, output logic busy_seen);
    push(d);
    record(nbits, v, tmo);
    @(negedge clk);
    done_seen = tx_done;
    busy_seen = tx_busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 7;
    if (tx !== 1'b1)         begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
    if (tx_busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", tx_busy); end
    if (tx_done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b want 0", tx_done); end
    if (fifo_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", fifo_empty); end
    if (fifo_full !== 1'b0)  begin errors++; $display("FAIL reset_full got %b want 0", fifo_full); end
    if (wr_ready !== 1'b1)   begin errors++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
    rst = 1'b0;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [15:0] v; bit tmo; logic dn, bz; int d0;
    cfg_data_len = 4'd8; cfg_parity = 3'b000; cfg_stop2 = 1'b0; tx_enable = 1'b1;
    d0 = done_cnt;
    send_frame(8'h55, 10, v, tmo, dn, bz);
    checks += 4;
    if (tmo) begin errors++; $display("FAIL basic_timeout got timeout want frame"); end
    if (v[9:0] !== 10'b1010101010) begin errors++; $display("FAIL basic_bits got %b want 1010101010", v[9:0]); end
    if (dn !== 1'b1) begin errors++; $display("FAIL basic_done got %b want 1", dn); end
    if (bz !== 1'b0) begin errors++; $display("FAIL basic_busy_fall got %b want 0", bz); end
    @(negedge clk);
    checks += 2;
    if (tx_done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b want 0", tx_done); end
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", done_cnt - d0); end
    $display("test_basic frame %b", v[9:0]);
  endtask

  task automatic test_parity_stop2();
    logic [15:0] v; bit tmo; logic dn, bz;
    cfg_data_len = 4'd7; cfg_parity = 3'b001; cfg_stop2 = 1'b1;
    send_frame(8'h03, 11, v, tmo, dn, bz);
    checks += 3;
    if (tmo) begin errors++; $display("FAIL odd_stop2_timeout got timeout want frame"); end
    if (v[10:0] !== 11'b111_0000011_0) begin errors++; $display("FAIL odd_stop2_bits got %b want 11100000110", v[10:0]); end
    if (dn !== 1'b1) begin errors++; $display("FAIL odd_stop2_done got %b want 1", dn); end
    $display("test_parity_stop2 frame %b", v[10:0]);
  endtask

  task automatic test_formats();
    logic [15:0] v; bit tmo; logic dn, bz;
    cfg_stop2 = 1'b0;
    // len 2 clamps to 5, even parity over five ones -> parity 1
    cfg_data_len = 4'd2; cfg_parity = 3'b010;
    send_frame(8'hFF, 8, v, tmo, dn, bz);
    checks += 2;
    if (tmo || v[7:0] !== 8'b1_1_11111_0) begin errors++; $display("FAIL clamp_low got %b want 11111110", v[7:0]); end
    if (dn !== 1'b1) begin errors++; $display("FAIL clamp_low_done got %b want 1", dn); end
    $display("test_formats clamp_low %b", v[7:0]);
    cfg_data_len = 4'd15; cfg_parity = 3'b000;
    send_frame(8'h81, 10, v, tmo, dn, bz);
    checks += 2;
    if (tmo || v[9:0] !== 10'b1_10000001_0) begin errors++; $display("FAIL clamp_high got %b want 1100000010", v[9:0]); end
    if (dn !== 1'b1) begin errors++; $display("FAIL clamp_high_done got %b want 1", dn); end
    $display("test_formats clamp_high %b", v[9:0]);
    cfg_data_len = 4'd5; cfg_parity = 3'b011;
    send_frame(8'h00, 8, v, tmo, dn, bz);
    checks += 2;
    if (tmo || v[7:0] !== 8'b1_1_00000_0) begin errors++; $display("FAIL mark got %b want 11000000", v[7:0]); end
    if (dn !== 1'b1) begin errors++; $display("FAIL mark_done got %b want 1", dn); end
    $display("test_formats mark %b", v[7:0]);
    cfg_data_len = 4'd6; cfg_parity = 3'b100;
    send_frame(8'hFF, 9, v, tmo, dn, bz);
    checks += 2;
    if (tmo || v[8:0] !== 9'b1_0_111111_0) begin errors++; $display("FAIL space got %b want 101111110", v[8:0]); end
    if (dn !== 1'b1) begin errors++; $display("FAIL space_done got %b want 1", dn); end
    $display("test_formats space %b", v[8:0]);
    cfg_data_len = 4'd8; cfg_parity = 3'b000;
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [16];
    logic [15:0] v; bit tmo;
    tx_enable = 1'b0;
    for (int i = 0; i < 16; i++) begin
      vals[i] = 8'(i * 29 + 7);
      push(vals[i]);
    end
    checks += 4;
    if (fifo_count !== 5'd16) begin errors++; $display("FAIL full_count got %0d want 16", fifo_count); end
    if (fifo_full !== 1'b1)   begin errors++; $display("FAIL full_flag got %b want 1", fifo_full); end
    if (wr_ready !== 1'b0)    begin errors++; $display("FAIL full_wr_ready got %b want 0", wr_ready); end
    if (tx_busy !== 1'b0)     begin errors++; $display("FAIL full_held got busy %b want 0", tx_busy); end
    push(8'hEE);
    checks++;
    if (fifo_count !== 5'd16) begin errors++; $display("FAIL overflow_drop got %0d want 16", fifo_count); end
    gap_cnt = 0;
    tx_enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      record(10, v, tmo);
      if (i == 0) watch_gap = 1'b1;
      if (i == 15) watch_gap = 1'b0;
      checks++;
      if (tmo || v[9:0] !== {1'b1, vals[i], 1'b0})
        begin errors++; $display("FAIL b2b_frame%0d got %b want %b", i, v[9:0], {1'b1, vals[i], 1'b0}); end
      $display("test_back_to_back frame %0d data %h", i, v[8:1]);
    end
    @(negedge clk);
    checks += 3;
    if (gap_cnt !== 0)        begin errors++; $display("FAIL b2b_idle_gap got %0d want 0", gap_cnt); end
    if (fifo_empty !== 1'b1)  begin errors++; $display("FAIL b2b_empty got %b want 1", fifo_empty); end
    if (tx_done !== 1'b1)     begin errors++; $display("FAIL b2b_last_done got %b want 1", tx_done); end
  endtask

  task automatic test_break();
    logic [15:0] v; bit tmo; int n; int bad;
    tx_enable = 1'b1;
    push(8'hA5);
    push(8'h3C);
    n = 0;
    while (tx_busy !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
    // break and config changes arrive mid-frame and must not disturb it
    cfg_break = 1'b1; cfg_data_len = 4'd5; cfg_parity = 3'b001; cfg_stop2 = 1'b1;
    record(10, v, tmo);
    checks++;
    if (tmo || v[9:0] !== 10'b1_10100101_0) begin errors++; $display("FAIL brk_frame got %b want 1101001010", v[9:0]); end
    @(negedge clk);
    checks++;
    if (tx_done !== 1'b1) begin errors++; $display("FAIL brk_frame_done got %b want 1", tx_done); end
    @(negedge clk);
    checks += 2;
    if (tx !== 1'b0)      begin errors++; $display("FAIL brk_low got %b want 0", tx); end
    if (tx_busy !== 1'b1) begin errors++; $display("FAIL brk_busy got %b want 1", tx_busy); end
    cfg_data_len = 4'd8; cfg_parity = 3'b000; cfg_stop2 = 1'b0;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (tx !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL brk_hold got %0d high samples want 0", bad); end
    cfg_break = 1'b0;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL brk_mark got %b want 1", tx); end
    n = 0;
    while (baud_tick !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL brk_mark_tick got %b want 1", tx); end
    record(10, v, tmo);
    checks++;
    if (tmo || v[9:0] !== 10'b1_00111100_0) begin errors++; $display("FAIL brk_next_frame got %b want 1001111000", v[9:0]); end
    @(negedge clk);
    $display("test_break queued frame %b", v[9:0]);
  endtask

  task automatic test_reset_mid();
    int n; int d0; int bad;
    tx_enable = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
    checks++;
    if (fifo_count !== 5'd4) begin errors++; $display("FAIL rstmid_fill got %0d want 4", fifo_count); end
    tx_enable = 1'b1;
    n = 0;
    while (tx_busy !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
    repeat (2) begin
      @(negedge clk);
      n = 0;
      while (baud_tick !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
    end
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    checks += 5;
    if (tx !== 1'b1)         begin errors++; $display("FAIL rstmid_tx got %b want 1", tx); end
    if (fifo_count !== 5'd0) begin errors++; $display("FAIL rstmid_count got %0d want 0", fifo_count); end
    if (tx_busy !== 1'b0)    begin errors++; $display("FAIL rstmid_busy got %b want 0", tx_busy); end
    if (tx_done !== 1'b0)    begin errors++; $display("FAIL rstmid_done got %b want 0", tx_done); end
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty got %b want 1", fifo_empty); end
    push(8'h77);
    checks++;
    if (fifo_count !== 5'd0) begin errors++; $display("FAIL rstmid_write_blocked got %0d want 0", fifo_count); end
    rst = 1'b0;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    checks += 2;
    if (bad !== 0)          begin errors++; $display("FAIL rstmid_quiet got %0d active samples want 0", bad); end
    if (done_cnt !== d0)    begin errors++; $display("FAIL rstmid_no_done got %0d pulses want 0", done_cnt - d0); end
    $display("test_reset_mid count %0d", fifo_count);
  endtask

  task automatic test_simul_rw();
    logic [7:0] vals [16];
    logic [15:0] v; bit tmo;
    tx_enable = 1'b0;
    for (int i = 0; i < 15; i++) begin
      vals[i] = 8'(8'hF0 - i * 7);
      push(vals[i]);
    end
    vals[15] = 8'hC3;
    checks++;
    if (fifo_count !== 5'd15) begin errors++; $display("FAIL simul_pre got %0d want 15", fifo_count); end
    tx_enable = 1'b1;
    wr_data = vals[15];
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    checks += 2;
    if (fifo_count !== 5'd15) begin errors++; $display("FAIL simul_count got %0d want 15", fifo_count); end
    if (tx_busy !== 1'b1)     begin errors++; $display("FAIL simul_popped got busy %b want 1", tx_busy); end
    for (int i = 0; i < 16; i++) begin
      record(10, v, tmo);
      checks++;
      if (tmo || v[9:0] !== {1'b1, vals[i], 1'b0})
        begin errors++; $display("FAIL simul_frame%0d got %b want %b", i, v[9:0], {1'b1, vals[i], 1'b0}); end
      $display("test_simul_rw frame %0d data %h", i, v[8:1]);
    end
    @(negedge clk);
    checks++;
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL simul_empty got %b want 1", fifo_empty); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_stop2();
    test_formats();
    test_back_to_back();
    test_break();
    test_reset_mid();
    test_simul_rw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the maximum data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, giving the transmit FIFO entry count; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port baud_tick, input, 1 bit: one-clk pulse marking the end of a bit period.
REQ-006 SHALL have port tx_enable, input, 1 bit: permits starting new frames.
REQ-007 SHALL have port cfg_data_len, input, 4 bits: data bits per frame; values below 5 are treated as 5 and values above DATA_W as DATA_W.
REQ-008 SHALL have port cfg_stop2, input, 1 bit: 0 gives one stop bit, 1 gives two.
REQ-009 SHALL have port cfg_parity, input, 3 bits: 000 none, 001 odd, 010 even, 011 mark (1), 100 space (0); other codes mean none.
REQ-010 SHALL have port cfg_break, input, 1 bit: break request.
REQ-011 SHALL have port wr_valid, input, 1 bit: write request.
REQ-012 SHALL have port wr_data, input, DATA_W bits: write data.
REQ-013 SHALL have port wr_ready, output, 1 bit, equal to !fifo_full.
REQ-014 SHALL have port tx, output, 1 bit, registered: the serial line.
REQ-015 SHALL have port tx_busy, output, 1 bit, registered: high whenever state is not IDLE.
REQ-016 SHALL have port tx_done, output, 1 bit, registered: one-clk frame-complete pulse.
REQ-017 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: current number of FIFO entries.
REQ-018 SHALL have ports fifo_empty and fifo_full, output, 1 bit each: FIFO status flags.

Function
REQ-019 SHALL write wr_data into the FIFO in a cycle where wr_valid && wr_ready; writes are ignored when the FIFO is full.
REQ-020 SHALL let a write and a pop in the same cycle both take effect, leaving fifo_count unchanged.
REQ-021 SHALL wrap FIFO pointers modulo FIFO_DEPTH, keeping entries in strict FIFO order.
REQ-022 SHALL use the states IDLE, START, DATA, PARITY, STOP, BREAK and BREAK_MARK.
REQ-023 SHALL, in IDLE with cfg_break=1, enter BREAK and drive tx=0 on the same edge, regardless of tx_enable or FIFO state.
REQ-024 SHALL, in IDLE with cfg_break=0, tx_enable=1 and FIFO non-empty, pop the head entry, latch cfg_data_len, cfg_stop2 and cfg_parity, enter START and drive tx=0 on the same edge.
REQ-025 SHALL have tx change only on the same edge as a state or bit-index change, so each bit spans from that edge to the edge where baud_tick=1 is sampled.
REQ-026 SHALL, in START on baud_tick, enter DATA at bit 0, driving tx=data[0].
REQ-027 SHALL, in DATA on baud_tick, advance to the next bit, LSB first; after bit (len-1) it enters PARITY if parity is enabled, otherwise STOP.
REQ-028 SHALL never transmit data bits at index len or above.
REQ-029 SHALL compute parity once at pop time over data[len-1:0] using the latched configuration: odd makes the 1-count including parity odd, even makes it even, mark sends 1, space sends 0.
REQ-030 SHALL, in PARITY on baud_tick, enter STOP with tx=1.
REQ-031 SHALL, in STOP, count 1 or 2 baud_ticks per the latched cfg_stop2; on the final tick it pulses tx_done for exactly one clk.
REQ-032 SHALL, on that final stop tick, start the next frame back-to-back if the IDLE start condition (REQ-024) holds, entering START directly with no idle cycle; otherwise it enters IDLE.
REQ-033 SHALL, in BREAK, hold tx=0 while cfg_break=1; when cfg_break=0 it enters BREAK_MARK with tx=1.
REQ-034 SHALL, in BREAK_MARK, enter IDLE on the next baud_tick.
REQ-035 SHALL ignore cfg_break during a frame; a pending break is honoured in IDLE after the frame and takes priority over a back-to-back start.
REQ-036 SHALL let a frame in progress complete when tx_enable falls, then remain in IDLE while tx_enable=0.
REQ-037 SHALL ignore configuration input changes during a frame; only the latched copy is used.
REQ-038 SHALL ignore baud_tick in IDLE.

Reset
REQ-039 SHALL, when rst=1 at a clk edge, set tx=1, tx_busy=0, tx_done=0, state=IDLE, FIFO pointers=0, fifo_count=0, fifo_empty=1, fifo_full=0 and wr_ready=1.
REQ-040 SHALL, on reset during a frame or break, abort it, discard FIFO contents, and drive tx=1 from the reset edge.
REQ-041 SHALL, while rst=1, accept no writes and start no frames.

Verification
REQ-042 SHALL pass: cfg len=8, parity none, stop1, write 0x55 -> tx 0,1,0,1,0,1,0,1,0,1 per baud period; one tx_done pulse; tx_busy falls on the same edge.
REQ-043 SHALL pass: len=7, odd parity, stop2, write 0x03 -> data 1,1,0,0,0,0,0; parity 1; two stop bits; bit 7 not sent.
REQ-044 SHALL pass: fill FIFO with FIFO_DEPTH writes while tx_enable=0 -> fifo_full=1, wr_ready=0, an extra write is dropped; enable -> all frames sent in order back-to-back with no idle cycle; fifo_empty=1 at the end.
REQ-045 SHALL pass: cfg_break raised mid-frame -> frame completes, then tx=0 until cfg_break falls, then one mark baud period, then the queued frame starts.
REQ-046 SHALL pass: rst asserted in the DATA state with 3 entries queued -> next edge gives tx=1, fifo_count=0, tx_busy=0, and no tx_done.
REQ-047 SHALL pass: simultaneous write and pop at fifo_count=FIFO_DEPTH-1 -> count unchanged and no data lost.
